// File: rtl/neuron_integrate_if.sv
// rtl/neuron_integrate_if.sv - weight-row read bus and lateral-inhibition handshake
interface neuron_integrate_if #(
    parameter int N  = 8,
    parameter int M  = 16,
    parameter int WW = 8
);
    localparam int AW = (M > 1) ? $clog2(M) : 1;

    logic [AW-1:0]   w_addr;
    logic            w_rd_en;
    logic [N*WW-1:0] w_data;
    logic            start_li;
    logic            valid_li;
    logic            first_spike;

    modport master (
        output w_addr, w_rd_en, start_li,
        input  w_data, valid_li, first_spike
    );

    modport slave (
        input  w_addr, w_rd_en, start_li,
        output w_data, valid_li, first_spike
    );
endinterface

// File: rtl/neuron_integrate.sv
// rtl/neuron_integrate.sv - per-timestep synaptic integration with saturation, leak and inhibition reset
module neuron_integrate #(
    parameter int W    = 24,
    parameter int N    = 8,
    parameter int M    = 16,
    parameter int WW   = 8,
    parameter int LEAK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic [M-1:0]         spike_in,
    neuron_integrate_if.master   wb,
    output logic [N*W-1:0]       potentials,
    output logic                 busy,
    output logic                 done
);
    localparam int            AW     = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0]  LEAK_W = W'(LEAK);
    localparam logic [AW-1:0] LAST   = AW'(M - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACC     = 3'd1,
        S_DRAIN   = 3'd2,
        S_LEAK    = 3'd3,
        S_FIRE    = 3'd4,
        S_WAIT_LI = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [M-1:0]   spk_q, spk_d;
    logic           pv_q, pv_d;
    logic [AW-1:0]  pidx_q, pidx_d;
    logic [N*W-1:0] pot_q, pot_d;
    logic [N*W-1:0] acc_pot;
    logic [N*W-1:0] leak_pot;
    logic [W:0]     sum;
    logic           rd_en, li_pulse;

    // Saturating row add and floor-at-zero leak, both per neuron
    always_comb begin
        acc_pot  = '0;
        leak_pot = '0;
        sum      = '0;
        for (int n = 0; n < N; n++) begin
            sum = {1'b0, pot_q[n*W +: W]} + {{(W+1-WW){1'b0}}, wb.w_data[n*WW +: WW]};
            acc_pot[n*W +: W]  = sum[W] ? {W{1'b1}} : sum[W-1:0];
            leak_pot[n*W +: W] = (pot_q[n*W +: W] >= LEAK_W) ? (pot_q[n*W +: W] - LEAK_W) : '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        spk_d    = spk_q;
        pv_d     = 1'b0;
        pidx_d   = pidx_q;
        pot_d    = pot_q;
        rd_en    = 1'b0;
        li_pulse = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear) pot_d = '0;
                if (start) begin
                    spk_d   = spike_in;
                    idx_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                busy   = 1'b1;
                rd_en  = 1'b1;
                pv_d   = 1'b1;
                pidx_d = idx_q;
                if (pv_q && spk_q[pidx_q]) pot_d = acc_pot;
                // idx parks on the last row so w_addr holds after the burst
                if (idx_q == LAST) state_d = S_DRAIN;
                else               idx_d   = idx_q + 1'b1;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (pv_q && spk_q[pidx_q]) pot_d = acc_pot;
                state_d = S_LEAK;
            end
            S_LEAK: begin
                busy    = 1'b1;
                pot_d   = leak_pot;
                state_d = S_FIRE;
            end
            S_FIRE: begin
                busy     = 1'b1;
                li_pulse = 1'b1;
                state_d  = S_WAIT_LI;
            end
            S_WAIT_LI: begin
                busy = 1'b1;
                if (wb.valid_li) begin
                    if (wb.first_spike) pot_d = '0;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            spk_q   <= '0;
            pv_q    <= 1'b0;
            pidx_q  <= '0;
            pot_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            spk_q   <= spk_d;
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
            pot_q   <= pot_d;
        end
    end

    assign wb.w_addr   = idx_q;
    assign wb.w_rd_en  = rd_en;
    assign wb.start_li = li_pulse;
    assign potentials  = pot_q;
endmodule

// File: tb/tb_neuron_integrate.sv
// tb/tb_neuron_integrate.sv - directed self-checking bench for neuron_integrate
module tb_neuron_integrate;
    localparam int W  = 12;
    localparam int N  = 8;
    localparam int M  = 16;
    localparam int WW = 8;
    localparam int AW = $clog2(M);

    logic           clk = 1'b0;
    logic           rst, start, clear;
    logic [M-1:0]   spike_in;
    logic [N*W-1:0] potentials;
    logic           busy, done;
    logic [N*WW-1:0] wmem [M];
    int total = 0;
    int bad   = 0;

    neuron_integrate_if #(.N(N), .M(M), .WW(WW)) nw ();

    neuron_integrate #(.W(W), .N(N), .M(M), .WW(WW), .LEAK(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .spike_in   (spike_in),
        .wb         (nw),
        .potentials (potentials),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Weight memory: one-cycle read latency
    always @(posedge clk) begin
        if (nw.w_rd_en) nw.w_data <= wmem[nw.w_addr];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] rep(input int v);
        logic [N*W-1:0] r;
        for (int n = 0; n < N; n++) r[n*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [N*WW-1:0] row_all(input int v);
        logic [N*WW-1:0] r;
        for (int n = 0; n < N; n++) r[n*WW +: WW] = WW'(v);
        return r;
    endfunction

    task automatic fill_rows(input int v);
        for (int r = 0; r < M; r++) wmem[r] = row_all(v);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_step(input string tag, input logic [M-1:0] sp, input logic clr,
                            input logic inj, input int delay, input logic fs,
                            input logic [N*W-1:0] exp_fire, input logic [N*W-1:0] exp_after);
        int   cyc;
        logic found;
        spike_in = sp;
        start    = 1'b1;
        clear    = clr;
        cyc      = 0;
        found    = 1'b0;
        while (cyc < 100 && !found) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; clear = 1'b0; nw.valid_li = 1'b0; nw.first_spike = 1'b0;
            if (nw.start_li) found = 1'b1;
            else if (inj && cyc == 5) begin
                start = 1'b1; clear = 1'b1; nw.valid_li = 1'b1; nw.first_spike = 1'b1;
            end
        end
        chk({tag, "_lat"}, 128'(cyc), 128'd19);
        chk({tag, "_fire_pot"}, 128'(potentials), 128'(exp_fire));
        @(negedge clk);
        chk({tag, "_li_once"}, {nw.start_li, busy}, 2'b01);
        for (int i = 0; i < delay; i++) begin
            if (inj && i == 1) begin start = 1'b1; clear = 1'b1; end
            else begin start = 1'b0; clear = 1'b0; end
            @(negedge clk);
            chk({tag, "_hold"}, {busy, done, potentials}, {1'b1, 1'b0, exp_fire});
        end
        start = 1'b0; clear = 1'b0;
        nw.valid_li = 1'b1; nw.first_spike = fs;
        @(negedge clk);
        nw.valid_li = 1'b0; nw.first_spike = 1'b0;
        chk({tag, "_done"}, {done, potentials}, {1'b1, exp_after});
        chk({tag, "_addr"}, {nw.w_rd_en, nw.w_addr}, {1'b0, AW'(M - 1)});
        @(negedge clk);
        chk({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    initial begin
        logic [N*W-1:0] vec;
        int k;
        rst = 1'b1; start = 1'b0; clear = 1'b0; spike_in = '0;
        nw.valid_li = 1'b0; nw.first_spike = 1'b0;
        fill_rows(0);
        repeat (3) @(negedge clk);
        chk("rst_pot", 128'(potentials), 128'd0);
        chk("rst_ctl", {busy, done, nw.w_rd_en, nw.start_li, nw.w_addr}, '0);

        // Single spike on row 0, row 1 loaded but not spiking; start on first edge after reset
        rst = 1'b0;
        wmem[0] = row_all(10);
        wmem[1] = row_all(7);
        run_step("basic", 16'h0001, 1'b0, 1'b0, 0, 1'b0, rep(9), rep(9));

        // Winner spiked: all potentials cleared
        wmem[0] = row_all(101);
        run_step("inhib", 16'h0001, 1'b1, 1'b0, 2, 1'b1, rep(100), rep(0));

        // No input spikes: leak floors at zero, then 5 -> 4
        run_step("zero", 16'h0000, 1'b0, 1'b0, 0, 1'b0, rep(0), rep(0));
        wmem[0] = row_all(6);
        run_step("five", 16'h0001, 1'b0, 1'b0, 0, 1'b0, rep(5), rep(5));
        run_step("leak4", 16'h0000, 1'b0, 1'b0, 0, 1'b0, rep(4), rep(4));

        // clear with start restarts from zero; stray start/clear/valid_li ignored; long LI wait
        wmem[0] = row_all(10);
        run_step("clrst", 16'h0001, 1'b1, 1'b1, 20, 1'b0, rep(9), rep(9));

        // Distinct per-neuron weights: row0 = n+1, row3 = 2n, row1 not spiked
        fill_rows(0);
        wmem[1] = row_all(50);
        for (int n = 0; n < N; n++) begin
            wmem[0][n*WW +: WW] = WW'(n + 1);
            wmem[3][n*WW +: WW] = WW'(2 * n);
            vec[n*W +: W]       = W'(3 * n);
        end
        run_step("perneu", 16'h0009, 1'b1, 1'b0, 0, 1'b0, vec, vec);

        // Saturation: 16*255 = 4080 -> 4079, then 4079+4080 clips at 4095 -> 4094
        fill_rows(255);
        run_step("sat1", 16'hFFFF, 1'b1, 1'b0, 0, 1'b0, rep(4079), rep(4079));
        run_step("sat2", 16'hFFFF, 1'b0, 1'b0, 0, 1'b0, rep(4094), rep(4094));

        // Reset in the middle of ACC at idx 7
        fill_rows(0);
        wmem[0] = row_all(10);
        spike_in = 16'h0001; start = 1'b1;
        k = 0;
        @(negedge clk);
        start = 1'b0;
        while (!(nw.w_rd_en && nw.w_addr == AW'(7)) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("mid_acc_seen", {nw.w_rd_en, nw.w_addr}, {1'b1, AW'(7)});
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pot", 128'(potentials), 128'd0);
        chk("midrst_ctl", {busy, done, nw.w_rd_en, nw.start_li, nw.w_addr}, '0);
        rst = 1'b0;
        run_step("after_rst", 16'h0001, 1'b0, 1'b0, 0, 1'b0, rep(9), rep(9));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
